keypad_encoder: RTL
===================

// Module: keypad_encoder
// PURPOSE
//  Scans the 4-row x 6-column calculator keypad and produces the key-event interface consumed by the
//  Registers block: newhex/hexcode, newop/opcode, eq. Debounces each press and release, emits exactly
//  one single-cycle event per debounced press, and holds the code outputs stable between events.
//  Sits between the keypad pins and Registers, in the same clock domain.
// PARAMETERS
//  SCAN_DIV  5000  clock cycles per scan tick (1 ms at 5 MHz); must be >= 4
//  DEBOUNCE  4     consecutive agreeing ticks needed to accept a press and to accept a release
// PORTS
//  clock    in   1  system clock, rising edge
//  reset    in   1  synchronous, active-low reset (0 = reset)
//  row      in   4  keypad rows, active-low, pulled up, asynchronous to clock
//  col      out  6  keypad column drive, one-hot active-low
//  newhex   out  1  1-cycle pulse: hex digit key accepted
//  hexcode  out  4  digit of last hex key; held between pulses
//  newop    out  1  1-cycle pulse: operator key accepted
//  opcode   out  2  code of last operator key; held between pulses
//  eq       out  1  1-cycle pulse: equals key accepted
// BEHAVIOUR
//  - reset=0 at a clock edge: col=6'b111110, newhex=newop=eq=0, hexcode=0, opcode=0,
//    tick counter=0, debounce count=0, state=SCAN. Reset dominates every state; a pending key is dropped.
//  - row passes through a 2-FF synchronizer; all decisions use the synchronized value rs.
//  - Tick counter runs 0..SCAN_DIV-1 in every state and wraps; tick=1 for the cycle it equals SCAN_DIV-1.
//    All sampling of rs happens only on tick cycles.
//  - Key map, index = col*4+row: cols 0-3 -> hex digit col*4+row (0x0-0xF); col 4 rows 0-3 ->
//    opcode 0-3; col 5 row 0 -> eq; col 5 rows 1-3 -> unused (debounced, no event).
//  - FSM:
//    SCAN: on tick, if exactly one bit of rs is 0 -> latch {col,row}, cnt=1, go DEB_PRESS, col unchanged;
//          else (none, or >=2 rows low) advance col one-hot 0->1->..->5->0.
//    DEB_PRESS: on tick, same single row low -> cnt+1; when cnt reaches DEBOUNCE -> EMIT.
//          Any other rs pattern -> SCAN, advance col.
//    EMIT (1 cycle): hex key -> newhex=1 and hexcode=digit in the same cycle; op key -> newop=1 and
//          opcode=code; eq key -> eq=1; unused key -> nothing. Codes of the other class unchanged.
//          cnt=0 -> WAIT_REL.
//    WAIT_REL: col held on latched column; on tick, rs==4'hF -> cnt+1, else cnt=0;
//          cnt reaching DEBOUNCE -> SCAN, advance col.
//  - Pulses are registered, high for exactly one clock, never two at once.
//  - Press latency: DEBOUNCE-1 ticks after first detecting tick, +1 cycle for EMIT.
//  - Rollover: while in DEB_PRESS/EMIT/WAIT_REL only the latched column is driven, so keys in other
//    columns are ignored; a second key in the same column resets the release count (no event).
//  - A key held through reset is re-detected after reset and emitted once.
// STRUCTURE
//  - calc_pkg: opcode constants (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3), key-class enum
//    (KEY_HEX, KEY_OP, KEY_EQ, KEY_NONE), NUM_ROWS=4, NUM_COLS=6; shared with Registers.
//  - Sub-module keypad_sync: 2-FF synchronizer for row, reset to 4'hF. Tick counter, FSM and
//    key-map decode stay in keypad_encoder.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE=3, keypad model drives row from col)
//  1 reset=0 two cycles, no keys -> col=111110, outputs 0; release -> col steps 0..5 and wraps to 0 every 4 cycles.
//  2 hold key col1/row1 for 20 ticks -> exactly one newhex pulse, hexcode=5; newop/eq stay 0.
//  3 key col2/row3 bounces on/off 2 ticks then steady -> one newhex, hexcode=0xB; none during bounce.
//  4 col4/row2 -> newop 1 cycle, opcode=2, hexcode still 0xB; col5/row0 -> one eq pulse;
//    col5/row1 -> no pulse.
//  5 col1/row0 and col1/row2 low together -> no event; hold col3/row2 (0xE), press col0/row3 ->
//    only 0xE emitted; 0x3 emitted only after 0xE released >=3 ticks and 0x3 re-debounced.
//  6 reset=0 in DEB_PRESS -> no pulse, col=111110; release, press col0/row1 -> newhex, hexcode=1.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad geometry, operator codes and key classification.
// Used by the keypad encoder and the Registers block.
package calc_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 6;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    KEY_HEX,
    KEY_OP,
    KEY_EQ,
    KEY_NONE
  } key_class_e;

  // Columns 0-3 are hex digits, column 4 operators, column 5 row 0 is equals.
  function automatic key_class_e key_class(input logic [2:0] c, input logic [1:0] r);
    if (c < 3'd4)      return KEY_HEX;
    else if (c == 3'd4) return KEY_OP;
    else if (r == 2'd0) return KEY_EQ;
    else                return KEY_NONE;
  endfunction

  function automatic logic [1:0] op_code(input logic [1:0] r);
    case (r)
      2'd0:    return OP_ADD;
      2'd1:    return OP_SUB;
      2'd2:    return OP_MUL;
      default: return OP_DIV;
    endcase
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the active-low keypad row inputs; idles at "no key" (all ones).
module keypad_sync
  import calc_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_async,
  output logic [NUM_ROWS-1:0] row_sync
);

  logic [NUM_ROWS-1:0] meta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta     <= '1;
      row_sync <= '1;
    end else begin
      meta     <= row_async;
      row_sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Scans the 4x6 calculator keypad, debounces press and release, and emits one
// single-cycle newhex/newop/eq event per accepted key with held code outputs.
module keypad_encoder
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic                newhex,
  output logic [3:0]          hexcode,
  output logic                newop,
  output logic [1:0]          opcode,
  output logic                eq
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] SCAN      = 2'd0;
  localparam logic [1:0] DEB_PRESS = 2'd1;
  localparam logic [1:0] EMIT      = 2'd2;
  localparam logic [1:0] WAIT_REL  = 2'd3;

  logic [NUM_ROWS-1:0] rs;
  logic [TW-1:0]       tcnt;
  logic                tick;
  logic [1:0]          state;
  logic [2:0]          col_idx;
  logic [2:0]          next_col;
  logic [1:0]          key_row;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_inc;
  logic                one_low;
  logic [1:0]          low_idx;
  key_class_e          kclass;

  keypad_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .row_async (row),
    .row_sync  (rs)
  );

  assign tick     = (tcnt == TW'(SCAN_DIV - 1));
  assign next_col = (col_idx == 3'(NUM_COLS - 1)) ? 3'd0 : col_idx + 3'd1;
  assign cnt_inc  = cnt + 1'b1;
  assign col      = ~(NUM_COLS'(1) << col_idx);
  assign kclass   = key_class(col_idx, key_row);

  // Two or more rows low in one column is ambiguous and treated like no key.
  always_comb begin
    one_low = 1'b0;
    low_idx = 2'd0;
    case (rs)
      4'b1110: begin one_low = 1'b1; low_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_idx = 2'd3; end
      default: begin one_low = 1'b0; low_idx = 2'd0; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tcnt    <= '0;
      state   <= SCAN;
      col_idx <= 3'd0;
      key_row <= 2'd0;
      cnt     <= '0;
      newhex  <= 1'b0;
      newop   <= 1'b0;
      eq      <= 1'b0;
      hexcode <= 4'd0;
      opcode  <= 2'd0;
    end else begin
      tcnt   <= tick ? '0 : tcnt + 1'b1;
      newhex <= 1'b0;
      newop  <= 1'b0;
      eq     <= 1'b0;
      case (state)
        SCAN: if (tick) begin
          if (one_low) begin
            key_row <= low_idx;
            cnt     <= CW'(1);
            state   <= DEB_PRESS;
          end else begin
            col_idx <= next_col;
          end
        end
        // Pulses are loaded on entry so they are high exactly during EMIT.
        DEB_PRESS: if (tick) begin
          if (one_low && (low_idx == key_row)) begin
            cnt <= cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE)) begin
              state <= EMIT;
              case (kclass)
                KEY_HEX: begin newhex <= 1'b1; hexcode <= {col_idx[1:0], key_row}; end
                KEY_OP:  begin newop  <= 1'b1; opcode  <= op_code(key_row); end
                KEY_EQ:  eq <= 1'b1;
                default: ;
              endcase
            end
          end else begin
            state   <= SCAN;
            col_idx <= next_col;
          end
        end
        EMIT: begin
          cnt   <= '0;
          state <= WAIT_REL;
        end
        WAIT_REL: if (tick) begin
          if (rs == '1) begin
            if (cnt_inc == CW'(DEBOUNCE)) begin
              cnt     <= '0;
              state   <= SCAN;
              col_idx <= next_col;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
